// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encodings
// and the supported operand width range.
package seq_div_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,qu} left, then trial-subtract the divisor.
// Purely combinational; the caller registers the outputs every CALC cycle.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] qu_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] qu_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] dvs_ext;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    shifted = {rem_in[WIDTH-1:0], qu_in[WIDTH-1]};
    dvs_ext = {1'b0, dvs};
    diff    = shifted - dvs_ext;
    // The partial remainder stays below the divisor, so its top bit is zero in practice;
    // folding it into the compare keeps the step correct for any input.
    ge      = rem_in[WIDTH] | (shifted >= dvs_ext);
    rem_out = ge ? diff : shifted;
    qu_out  = {qu_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Signed/unsigned restoring divider, one quotient bit per cycle; done pulses WIDTH+3 cycles after accept (2 for /0).
// No queuing: start is only honoured in IDLE with no done pulse pending, otherwise it is dropped.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("seq_divider: WIDTH out of supported range");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   prem_q, prem_d;
  logic [WIDTH-1:0] qu_q, qu_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_qu;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem_q),
    .qu_in   (qu_q),
    .dvs     (dvs_q),
    .rem_out (step_rem),
    .qu_out  (step_qu)
  );

  always_comb begin
    dvd_mag     = (sgn && dividend[WIDTH-1]) ? WIDTH'(0) - dividend : dividend;
    dvs_mag     = (sgn && divisor[WIDTH-1])  ? WIDTH'(0) - divisor  : divisor;

    state_d     = state_q;
    count_d     = count_q;
    prem_d      = prem_q;
    qu_d        = qu_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // done_q marks the pulse cycle, during which a new request must be ignored
        if (start && !done_q) begin
          if (divisor == '0) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else begin
            prem_d    = '0;
            qu_d      = dvd_mag;
            dvs_d     = dvs_mag;
            neg_quo_d = sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = sgn & dividend[WIDTH-1];
            count_d   = '0;
            state_d   = S_CALC;
          end
        end
      end
      S_CALC: begin
        prem_d  = step_rem;
        qu_d    = step_qu;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) state_d = S_FIX;
      end
      S_FIX: begin
        quotient_d  = neg_quo_q ? WIDTH'(0) - qu_q : qu_q;
        remainder_d = neg_rem_q ? WIDTH'(0) - prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
        dbz_d       = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      prem_q      <= '0;
      qu_q        <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      prem_q      <= prem_d;
      qu_q        <= qu_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, sgn8, busy8, done8, dbz8;
  logic [7:0]  dvd8, dvs8, q8, r8;
  logic        start16, sgn16, busy16, done16, dbz16;
  logic [15:0] dvd16, dvs16, q16, r16;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .dbz(dbz8), .quotient(q8), .remainder(r8)
  );

  seq_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .dividend(dvd16), .divisor(dvs16),
    .busy(busy16), .done(done16), .dbz(dbz16), .quotient(q16), .remainder(r16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one division at the current negedge and returns at a negedge one cycle after done,
  // so consecutive calls exercise back-to-back acceptance.
  task automatic run_div(input bit w16, input logic s, input logic [31:0] a_in,
                         input logic [31:0] b_in, input string tag, input int inj_at);
    int          w, n, sa, sb, elat;
    logic [31:0] mask, a, b, eq, er;
    logic        edbz, cur_busy, cur_done;
    bit          both, busy_seen;
    w = w16 ? 16 : 8;
    mask = (32'd1 << w) - 32'd1;
    a = a_in & mask;
    b = b_in & mask;
    both = 1'b0;
    busy_seen = 1'b0;
    if (b == 0) begin
      eq = mask; er = a; edbz = 1'b1; elat = 1;
    end else begin
      if (s) begin
        sa = int'(a << (32 - w)) >>> (32 - w);
        sb = int'(b << (32 - w)) >>> (32 - w);
        eq = 32'(sa / sb) & mask;   // most-negative / -1 wraps naturally under the mask
        er = 32'(sa % sb) & mask;
      end else begin
        eq = a / b;
        er = a % b;
      end
      edbz = 1'b0; elat = w + 2;
    end

    if (w16) begin start16 = 1'b1; sgn16 = s; dvd16 = a[15:0]; dvs16 = b[15:0]; end
    else     begin start8  = 1'b1; sgn8  = s; dvd8  = a[7:0];  dvs8  = b[7:0];  end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    sgn8 = 1'($urandom); dvd8 = 8'($urandom); dvs8 = 8'($urandom);
    sgn16 = 1'($urandom); dvd16 = 16'($urandom); dvs16 = 16'($urandom);

    for (n = 0; n < 40; n++) begin
      cur_busy = w16 ? busy16 : busy8;
      cur_done = w16 ? done16 : done8;
      if (n == 0) check({tag, " busy_after_accept"}, 32'(cur_busy), 32'(b != 0));
      busy_seen |= cur_busy;
      both |= cur_busy & cur_done;
      if (cur_done) break;
      if (w16) start16 = (n == inj_at); else start8 = (n == inj_at);
      if (n == inj_at) begin
        dvd8 = 8'h11; dvs8 = 8'h03; dvd16 = 16'h0011; dvs16 = 16'h0003;
      end
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(n), 32'(elat));
    check({tag, " quotient"}, w16 ? 32'(q16) : 32'(q8), eq);
    check({tag, " remainder"}, w16 ? 32'(r16) : 32'(r8), er);
    check({tag, " dbz"}, w16 ? 32'(dbz16) : 32'(dbz8), 32'(edbz));
    check({tag, " busy_with_done"}, 32'(both), 32'd0);
    if (b == 0) check({tag, " busy_on_dbz"}, 32'(busy_seen), 32'd0);

    // A request raised during the done pulse must be dropped.
    if (w16) begin start16 = 1'b1; dvd16 = 16'($urandom); dvs16 = 16'd1; end
    else     begin start8  = 1'b1; dvd8  = 8'($urandom);  dvs8  = 8'd1;  end
    @(negedge clk);
    start8 = 1'b0; start16 = 1'b0;
    check({tag, " done_single"}, w16 ? 32'(done16) : 32'(done8), 32'd0);
    check({tag, " start_in_done_ignored"}, w16 ? 32'(busy16) : 32'(busy8), 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    start8 = 1'b0; sgn8 = 1'b0; dvd8 = '0; dvs8 = '0;
    start16 = 1'b0; sgn16 = 1'b0; dvd16 = '0; dvs16 = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy8), 32'd0);
    check("reset done", 32'(done8), 32'd0);
    check("reset dbz", 32'(dbz8), 32'd0);
    check("reset quotient", 32'(q8), 32'd0);
    check("reset remainder", 32'(r8), 32'd0);
    check("reset quotient16", 32'(q16), 32'd0);
    rst = 1'b0;

    run_div(1'b0, 1'b0, 32'd100, 32'd7, "u100/7", -1);
    run_div(1'b0, 1'b1, 32'h9C, 32'd7, "s-100/7", -1);
    run_div(1'b0, 1'b1, 32'h80, 32'hFF, "s-128/-1", -1);
    run_div(1'b0, 1'b0, 32'd200, 32'd9, "inject_midcalc", 3);
    run_div(1'b0, 1'b0, 32'd55, 32'd0, "u55/0", -1);

    // Abort mid-CALC with reset; start asserted alongside reset must not launch anything.
    start8 = 1'b1; sgn8 = 1'b0; dvd8 = 8'd100; dvs8 = 8'd7;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start8 = 1'b1; dvs8 = 8'd5;
    @(negedge clk);
    check("abort busy", 32'(busy8), 32'd0);
    check("abort done", 32'(done8), 32'd0);
    check("abort dbz", 32'(dbz8), 32'd0);
    check("abort quotient", 32'(q8), 32'd0);
    check("abort remainder", 32'(r8), 32'd0);
    rst = 1'b0; start8 = 1'b0;
    seen = 1'b0;
    repeat (14) begin
      @(negedge clk);
      seen |= done8 | busy8;
    end
    check("abort no_activity", 32'(seen), 32'd0);

    run_div(1'b0, 1'b0, 32'd200, 32'd3, "u200/3", -1);
    repeat (40) run_div(1'b0, 1'($urandom), $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                        "rand8", -1);
    run_div(1'b1, 1'b0, 32'd65535, 32'd255, "u65535/255", -1);
    run_div(1'b1, 1'b1, 32'h8000, 32'hFFFF, "s16min/-1", -1);
    repeat (10) run_div(1'b1, 1'($urandom), $urandom, $urandom, "rand16", -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request; accepted only when busy=0.
REQ-005 Port: sgn  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 Port: dividend  input  WIDTH  numerator; sampled on the accepting edge.
REQ-007 Port: divisor  input  WIDTH  denominator; sampled on the accepting edge.
REQ-008 Port: busy  output  1  high from the edge after acceptance until done is asserted.
REQ-009 Port: done  output  1  single-cycle pulse; results valid in that cycle.
REQ-010 Port: dbz  output  1  divide-by-zero flag for the last result.
REQ-011 Port: quotient  output  WIDTH  registered quotient.
REQ-012 Port: remainder  output  WIDTH  registered remainder.

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; reset state IDLE.
REQ-014 IDLE, start=1, divisor!=0: latch operands and sgn, load operand magnitudes (absolute values when sgn=1), count=0, go to CALC.
REQ-015 IDLE, start=1, divisor=0: go to DONE; quotient = all ones, remainder = dividend, dbz=1.
REQ-016 CALC: one restoring step per cycle, MSB first: shift {rem,qu} left 1; if rem >= divisor magnitude, subtract it and set qu LSB=1.
REQ-017 The partial remainder SHALL be WIDTH+1 bits wide so no compare or subtract overflows.
REQ-018 CALC SHALL last exactly WIDTH cycles, then go to FIX.
REQ-019 FIX: negate quotient if sgn and operand signs differ; negate remainder if sgn and dividend negative; register outputs; dbz=0; go to DONE.
REQ-020 Signed results SHALL truncate toward zero; remainder sign follows dividend.
REQ-021 Signed most-negative / -1 SHALL wrap to quotient = most-negative, remainder = 0, with no flag.
REQ-022 DONE: done=1 for exactly one cycle, then return to IDLE.
REQ-023 Latency for divisor!=0: start accepted at edge k -> done high in the cycle after edge k+WIDTH+2.
REQ-024 Latency for divisor=0: done high in the cycle after edge k+1.
REQ-025 busy SHALL be high in CALC and FIX; busy and done SHALL never both be high.
REQ-026 start while busy=1 or done=1 SHALL be ignored, with no queuing.
REQ-027 Operand changes after the accepting edge SHALL have no effect on the result.
REQ-028 quotient, remainder and dbz SHALL hold their last values until the next FIX or divide-by-zero DONE.
REQ-029 Back-to-back: start high in the cycle after done SHALL be accepted.

Reset
REQ-030 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, dbz=0, quotient=0, remainder=0, and clear count and datapath registers.
REQ-031 rst asserted mid-operation SHALL abort it with no done pulse.
REQ-032 start coincident with rst SHALL be ignored.

Structure
REQ-033 Package seq_div_pkg SHALL hold the state encodings and the WIDTH range limits.
REQ-034 One sub-module, div_step, SHALL be the combinational shift/compare/subtract step, parametrised by WIDTH.
REQ-035 The counter SHALL be $clog2(WIDTH+1) bits; no division operator in RTL.

Verification
REQ-036 WIDTH=8, sgn=0, 100/7 -> quotient=14, remainder=2, dbz=0, done in the cycle after edge k+10.
REQ-037 WIDTH=8, sgn=1, 0x9C(-100)/7 -> quotient=0xF2(-14), remainder=0xFE(-2); and -128/-1 -> 0x80, 0.
REQ-038 WIDTH=8, 55/0 -> quotient=0xFF, remainder=55, dbz=1, done in the cycle after edge k+1, busy never high.
REQ-039 start pulsed mid-CALC with different operands -> ignored; the first result is unchanged; back-to-back start after done is accepted.
REQ-040 rst asserted at CALC cycle 4 -> all outputs 0 next cycle, no done pulse; a new 200/3 afterwards -> 66, 2.
REQ-041 WIDTH=16, sgn=0, 65535/255 -> quotient=257, remainder=0, done in the cycle after edge k+18.
